axil_cfg_bridge: RTL

- AXI4-Lite slave that terminates host register accesses and drives the cfg_wr/cfg_rd strobe interface consumed by the MAC configuration register bank.
- Converts AW/W/B and AR/R channel handshakes into single-cycle cfg_wr_en / cfg_rd_en pulses.
- Waits for cfg_rd_vld and returns the response.
- Sits between the interconnect and the register bank, in the s_axi_aclk domain.

---
 rtl/axil_cfg_bridge_if.sv | 57 +++++
 rtl/axil_cfg_bridge.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/axil_cfg_bridge_if.sv
// AXI4-Lite slave bus plus cfg strobe bus seen by axil_cfg_bridge.
interface axil_cfg_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // AXI4-Lite write channels
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [DATA_W-1:0] s_axi_wdata;
  logic [STRB_W-1:0] s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;

  // AXI4-Lite read channels
  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;

  // Register bank strobe interface
  logic              cfg_wr_en;
  logic [ADDR_W-1:0] cfg_wr_addr;
  logic [DATA_W-1:0] cfg_wr_data;
  logic              cfg_rd_en;
  logic [ADDR_W-1:0] cfg_rd_addr;
  logic              cfg_rd_vld;
  logic [DATA_W-1:0] cfg_rd_data;

  // Bridge view
  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_en, cfg_rd_addr,
    input  cfg_rd_vld, cfg_rd_data
  );

  // Host + register bank view
  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_en, cfg_rd_addr,
    output cfg_rd_vld, cfg_rd_data
  );
endinterface

// File: rtl/axil_cfg_bridge.sv
// AXI4-Lite slave terminating host accesses into single-cycle cfg_wr/cfg_rd strobes.
module axil_cfg_bridge #(
  parameter int unsigned REG_ADDR_WIDTH = 32,
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned RD_TIMEOUT     = 16
) (
  input logic            s_axi_aclk,
  input logic            s_axi_areset,
  axil_cfg_bridge_if.slave bus
);

  localparam int unsigned STRB_W = REG_DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = $clog2(RD_TIMEOUT + 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_t;

  // Write path state
  w_state_t                  w_state_q, w_state_d;
  logic                      aw_held_q, aw_held_d;
  logic                      w_held_q, w_held_d;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [REG_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [STRB_W-1:0]         wr_strb_q, wr_strb_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      cfg_wr_en_q, cfg_wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] cfg_wr_addr_q, cfg_wr_addr_d;
  logic [REG_DATA_WIDTH-1:0] cfg_wr_data_q, cfg_wr_data_d;

  // Read path state
  r_state_t                  r_state_q, r_state_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic [REG_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      cfg_rd_en_q, cfg_rd_en_d;
  logic [REG_ADDR_WIDTH-1:0] cfg_rd_addr_q, cfg_rd_addr_d;

  // Write FSM next-state and registered-output values
  always_comb begin
    w_state_d     = w_state_q;
    aw_held_d     = aw_held_q;
    w_held_d      = w_held_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_strb_d     = wr_strb_q;
    bresp_d       = bresp_q;
    cfg_wr_addr_d = cfg_wr_addr_q;
    cfg_wr_data_d = cfg_wr_data_q;
    case (w_state_q)
      W_IDLE: begin
        if (bus.s_axi_awvalid && awready_q) begin
          aw_held_d = 1'b1;
          wr_addr_d = bus.s_axi_awaddr;
        end
        if (bus.s_axi_wvalid && wready_q) begin
          w_held_d  = 1'b1;
          wr_data_d = bus.s_axi_wdata;
          wr_strb_d = bus.s_axi_wstrb;
        end
        if (aw_held_d && w_held_d) begin
          w_state_d = W_ISSUE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      W_ISSUE: begin
        bresp_d   = ((wr_addr_q[1:0] == 2'b00) && (&wr_strb_q)) ? RESP_OKAY : RESP_SLVERR;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (bvalid_q && bus.s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d   = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d    = (w_state_d == W_IDLE) && !w_held_d;
    bvalid_d    = (w_state_d == W_RESP);
    cfg_wr_en_d = (w_state_q == W_IDLE) && (w_state_d == W_ISSUE) &&
                  (wr_addr_d[1:0] == 2'b00) && (&wr_strb_d);
    if (cfg_wr_en_d) begin
      cfg_wr_addr_d = wr_addr_d;
      cfg_wr_data_d = wr_data_d;
    end
  end

  // Write FSM state and output registers
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_q     <= W_IDLE;
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_strb_q     <= '0;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= 2'b00;
      cfg_wr_en_q   <= 1'b0;
      cfg_wr_addr_q <= '0;
      cfg_wr_data_q <= '0;
    end else begin
      w_state_q     <= w_state_d;
      aw_held_q     <= aw_held_d;
      w_held_q      <= w_held_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_strb_q     <= wr_strb_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      cfg_wr_en_q   <= cfg_wr_en_d;
      cfg_wr_addr_q <= cfg_wr_addr_d;
      cfg_wr_data_q <= cfg_wr_data_d;
    end
  end

  // Read FSM next-state; a write strobe in the same cycle defers the read strobe
  always_comb begin
    r_state_d     = r_state_q;
    rd_addr_d     = rd_addr_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    cfg_rd_addr_d = cfg_rd_addr_q;
    case (r_state_q)
      R_IDLE: begin
        if (bus.s_axi_arvalid && arready_q) begin
          rd_addr_d = bus.s_axi_araddr;
          r_state_d = R_ISSUE;
        end
      end
      R_ISSUE: begin
        if (rd_addr_q[1:0] != 2'b00) begin
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          r_state_d = R_RESP;
        end else if (cfg_rd_en_q) begin
          cnt_d     = '0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.cfg_rd_vld) begin
          rdata_d   = bus.cfg_rd_data;
          rresp_d   = RESP_OKAY;
          r_state_d = R_RESP;
        end else if (cnt_d == CNT_W'(RD_TIMEOUT)) begin
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (bus.s_axi_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d   = (r_state_d == R_IDLE);
    rvalid_d    = (r_state_d == R_RESP);
    cfg_rd_en_d = (r_state_d == R_ISSUE) && (rd_addr_d[1:0] == 2'b00) &&
                  (w_state_d != W_ISSUE);
    if (cfg_rd_en_d) cfg_rd_addr_d = rd_addr_d;
  end

  // Read FSM state and output registers
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state_q     <= R_IDLE;
      rd_addr_q     <= '0;
      cnt_q         <= '0;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rresp_q       <= 2'b00;
      cfg_rd_en_q   <= 1'b0;
      cfg_rd_addr_q <= '0;
    end else begin
      r_state_q     <= r_state_d;
      rd_addr_q     <= rd_addr_d;
      cnt_q         <= cnt_d;
      arready_q     <= arready_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      rresp_q       <= rresp_d;
      cfg_rd_en_q   <= cfg_rd_en_d;
      cfg_rd_addr_q <= cfg_rd_addr_d;
    end
  end

  assign bus.s_axi_awready = awready_q;
  assign bus.s_axi_wready  = wready_q;
  assign bus.s_axi_bvalid  = bvalid_q;
  assign bus.s_axi_bresp   = bresp_q;
  assign bus.s_axi_arready = arready_q;
  assign bus.s_axi_rvalid  = rvalid_q;
  assign bus.s_axi_rdata   = rdata_q;
  assign bus.s_axi_rresp   = rresp_q;
  assign bus.cfg_wr_en     = cfg_wr_en_q;
  assign bus.cfg_wr_addr   = cfg_wr_addr_q;
  assign bus.cfg_wr_data   = cfg_wr_data_q;
  assign bus.cfg_rd_en     = cfg_rd_en_q;
  assign bus.cfg_rd_addr   = cfg_rd_addr_q;

endmodule
